add_seq_ctrl: RTL and testbench
===============================

// Module: add_seq_ctrl
// PURPOSE
//  Multi-cycle wide-add sequencer. Runs one 4-bit ripple-carry slice over WIDTH/4 cycles,
//  least-significant slice first, with the carry held in a register between slices.
//  Gives WIDTH-bit addition with valid/ready handshakes on both sides, in place of a WIDTH-bit combinational chain.
// PARAMETERS
//  WIDTH    16   operand width in bits; must be a multiple of 4 (elaboration $error otherwise)
//  SLICES   WIDTH/4  localparam, derived; number of slice cycles per operation
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand request
//  in_ready   out  1        block can accept operands
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  cin        in   1        carry-in to slice 0
//  op_sub     in   1        only with SUBTRACT_EN: 1 = a-b
//  out_valid  out  1        result available
//  out_ready  in   1        consumer accepts result
//  result     out  WIDTH+1  {carry_out, sum[WIDTH-1:0]}
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  Reset (any time, including mid-RUN): state=IDLE; operation abandoned.
//    Output values in reset: in_ready=1, out_valid=0, busy=0, result=0. Carry reg, slice idx and operand regs cleared.
//  IDLE: in_ready=1. On in_valid&&in_ready, capture a, b into shift regs and cin into carry reg; idx=0; go to RUN.
//  RUN: each cycle, slice adder computes a_sh[3:0]+b_sh[3:0]+carry.
//    - 4-bit sum shifts into the top of the sum reg (shift right by 4).
//    - a_sh and b_sh shift right by 4; carry reg takes the slice carry-out.
//    - After idx==SLICES-1 is processed, go to DONE with result={carry, sum}.
//  DONE: out_valid=1; result is stable. On out_ready, go to IDLE (out_valid drops the next cycle).
//  Latency: acceptance edge E -> out_valid high after edge E+SLICES.
//    Minimum issue interval is SLICES+2 cycles; no overlap between operations.
//  in_ready=0 in RUN and DONE; in_valid there is ignored, no capture.
//    Operand inputs may change after acceptance with no effect.
//  result holds its last value in IDLE until the next DONE; out_valid is the only qualifier.
//  out_ready outside DONE has no effect. out_ready arriving in the same cycle DONE is entered is honoured.
//  Arithmetic is unsigned modulo 2^(WIDTH+1); the carry wraps through every slice boundary.
// CONFIGURATION
//  SUBTRACT_EN defined: port op_sub exists and is captured with the operands.
//    op_sub=1: b is inverted at capture and carry-in is forced to 1; cin is ignored.
//    result[WIDTH]=1 means no borrow.
//  SUBTRACT_EN undefined: no op_sub port; addition only; no invert logic.
// STRUCTURE
//  Package add_seq_pkg holds:
//    - state enum typedef (IDLE, RUN, DONE)
//    - SLICE_W=4 constant
//    - clog2-based index width function
//  Sub-module rca_slice4: combinational 4-bit ripple-carry adder, ports (a[3:0], b[3:0], ci, co, s[3:0]).
//    It is built from 1-bit full adders and instantiated once.
//  add_seq_ctrl contains: FSM, shift regs, carry reg, slice index counter, handshake logic.
// TESTING (WIDTH=16)
//  1. a=16'h1234, b=16'h1111, cin=0 -> out_valid 4 cycles after acceptance, result=17'h02345.
//  2. a=16'hFFFF, b=16'h0001, cin=0 -> result=17'h10000 (carry crosses all 4 slice boundaries).
//  3. a=16'hFFFF, b=16'hFFFF, cin=1 -> result=17'h1FFFF.
//  4. Hold out_ready=0 for 5 cycles in DONE, pulse in_valid with new operands.
//     -> out_valid and result stay stable, in_ready=0, no capture; IDLE after out_ready=1.
//  5. Drop rst_n during the 2nd RUN cycle -> all outputs at reset values immediately.
//     A following op (a=16'h0F0F, b=16'h00F1) gives 17'h01000.
//  6. SUBTRACT_EN: op_sub=1, a=16'h0007, b=16'h0005 -> 17'h10002.
//     Then a=16'h0005, b=16'h0007 -> 17'h0FFFE (borrow).

Source files
------------

// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and constants for the multi-cycle wide-add sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int SLICE_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rca_slice4.sv
// rca_slice4: combinational 4-bit ripple-carry adder built from 1-bit full adders.
module rca_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic       co,
    output logic [3:0] s
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: WIDTH-bit adder sequenced over WIDTH/4 cycles through one 4-bit slice.
// Define SUBTRACT_EN to add the op_sub port (a-b via inverted b and forced carry-in).
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             busy
);

    localparam int SLICES = WIDTH / SLICE_W;
    localparam int IW     = idx_w(SLICES);
    localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

    if (WIDTH % SLICE_W != 0 || WIDTH < SLICE_W) begin : g_chk
        $error("add_seq_ctrl: WIDTH must be a positive multiple of 4");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [WIDTH:0]   res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [3:0]       s;
    logic             co;

`ifdef SUBTRACT_EN
    assign b_in = op_sub ? ~b : b;
    assign c_in = op_sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    rca_slice4 u_slice (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (c_q),
        .co (co),
        .s  (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        res_d   = res_q;
        idx_d   = idx_q;
        c_d     = c_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b_in;
                c_d     = c_in;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // slice sum enters at the top so the LS slice ends at bit 0
                a_d   = a_q >> SLICE_W;
                b_d   = b_q >> SLICE_W;
                c_d   = co;
                sum_d = WIDTH'({s, sum_q} >> SLICE_W);
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    res_d   = {co, sum_d};
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: randomized self-checking bench for add_seq_ctrl against an arithmetic model.
module tb_add_seq_ctrl;

    localparam int WIDTH  = 16;
    localparam int SLICES = WIDTH / 4;
`ifdef SUBTRACT_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             op_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH:0]   result;
    logic             busy;
    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUBTRACT_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + 1;
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        in_valid = 1'($urandom);
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        op_sub   = 1'($urandom);
    endtask

    task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c, input logic s);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("in_ready_idle", 32'(in_ready), 1);
        a        = x;
        b        = y;
        cin      = c;
        op_sub   = s;
        in_valid = 1'b1;
        step();
        scramble();
        check("busy_run", 32'(busy), 1);
        check("in_ready_run", 32'(in_ready), 0);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                          input logic s, input int hold, input bit early);
        logic [WIDTH:0] exp;
        int n = 0;
        exp = model(x, y, c, s);
        accept(x, y, c, s);
        out_ready = early;
        while (!out_valid && n < 20) begin
            step();
            n++;
            scramble();
        end
        check("latency", n, SLICES);
        check("result", 32'(result), 32'(exp));
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                step();
                check("hold_valid", 32'(out_valid), 1);
                check("hold_in_ready", 32'(in_ready), 0);
                check("hold_result", 32'(result), 32'(exp));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_result", 32'(result), 32'(exp));
    endtask

    initial begin
        repeat (2) step();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_result", 32'(result), 0);
        rst_n = 1'b1;
        step();

        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
        check("t1_value", 32'(result), 32'h02345);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1);
        check("t2_value", 32'(result), 32'h10000);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
        check("t3_value", 32'(result), 32'h1FFFF);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 5, 1'b0);

        accept(16'hABCD, 16'h1357, 1'b0, 1'b0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_result", 32'(result), 0);
        step();
        rst_n = 1'b1;
        step();
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 1'b0);
        check("t5_value", 32'(result), 32'h01000);

        if (SUB) begin
            run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
            check("t6_sub", 32'(result), 32'h10002);
            run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1, 1'b0);
            check("t6_borrow", 32'(result), 32'h0FFFE);
        end

        for (int k = 0; k < 40; k++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom) & SUB,
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
